// File: rtl/pokey_scan_pkg.sv
// Shared types and sizing helpers for the four-channel scan capture block.
package pokey_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    COMMIT = 2'd3
  } scan_state_t;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  // Bits needed to hold SETTLE_CYCLES-1; never narrower than one bit.
  function automatic int cnt_width(input int settle_cycles);
    return (settle_cycles > 1) ? $clog2(settle_cycles) : 1;
  endfunction

endpackage

// File: rtl/scan_settle_timer.sv
// Load/decrement settle counter; zero flags that the held select has settled.
module scan_settle_timer
  import pokey_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int CNT_W = cnt_width(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = RELOAD;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/chan_scan_capture.sv
// Round-robin 4:1 line scanner rebuilding a registered image of four sources.
// Optional two-scan debounce of the committed image when SCAN_DEBOUNCE_EN is defined.
module chan_scan_capture
  import pokey_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_CH        = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              a_in,
  output logic [SEL_W-1:0]  sel,
  output logic [NUM_CH-1:0] y_q,
  output logic              scan_done,
  output logic              changed,
  output logic              busy
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  scan_state_t       state_q, state_d;
  logic [SEL_W-1:0]  ch_q, ch_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [NUM_CH-1:0] raw_q, raw_d;
  logic [NUM_CH-1:0] prev_raw_q, prev_raw_d;
  logic [NUM_CH-1:0] y_d;
  logic              scan_done_q, scan_done_d;
  logic              changed_q, changed_d;
  logic              busy_q, busy_d;

  logic [NUM_CH-1:0] raw_smp;
  logic [NUM_CH-1:0] next_y;
  logic              cnt_load;
  logic              cnt_zero;

  scan_settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cnt_load),
    .dec   (state_q == SETTLE),
    .zero  (cnt_zero)
  );

  // Reload whenever the FSM is about to enter SETTLE.
  assign cnt_load = ((state_q == IDLE)   && enable) ||
                    ((state_q == SAMPLE) && (ch_q != LAST_CH)) ||
                    ((state_q == COMMIT) && enable);

  always_comb begin
    raw_smp       = raw_q;
    raw_smp[ch_q] = a_in;
  end

  always_comb begin
`ifdef SCAN_DEBOUNCE_EN
    next_y = (raw_smp & ~(raw_smp ^ prev_raw_q)) | (y_q & (raw_smp ^ prev_raw_q));
`else
    next_y = raw_smp;
`endif
  end

  // The image and its pulses are registered on the last sample so that
  // y_q, scan_done and changed all appear together in the COMMIT cycle.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    sel_d       = sel_q;
    raw_d       = raw_q;
    prev_raw_d  = prev_raw_q;
    y_d         = y_q;
    scan_done_d = 1'b0;
    changed_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = SETTLE;
          ch_d    = '0;
          sel_d   = '0;
        end
      end
      SETTLE: begin
        if (cnt_zero) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        raw_d = raw_smp;
        if (ch_q == LAST_CH) begin
          state_d     = COMMIT;
          y_d         = next_y;
          scan_done_d = 1'b1;
          changed_d   = |(next_y ^ y_q);
        end else begin
          state_d = SETTLE;
          ch_d    = ch_q + 1'b1;
          sel_d   = ch_q + 1'b1;
        end
      end
      COMMIT: begin
        prev_raw_d = raw_q;
        if (enable) begin
          state_d = SETTLE;
          ch_d    = '0;
          sel_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      sel_q       <= '0;
      raw_q       <= '0;
      prev_raw_q  <= '0;
      y_q         <= '0;
      scan_done_q <= 1'b0;
      changed_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      sel_q       <= sel_d;
      raw_q       <= raw_d;
      prev_raw_q  <= prev_raw_d;
      y_q         <= y_d;
      scan_done_q <= scan_done_d;
      changed_q   <= changed_d;
      busy_q      <= busy_d;
    end
  end

  assign sel       = sel_q;
  assign scan_done = scan_done_q;
  assign changed   = changed_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_chan_scan_capture.sv
// Bench for chan_scan_capture: external mux modelled as a_in = src[sel].
module tb_chan_scan_capture;

  localparam int S        = 2;
  localparam int SCAN_LEN = 4 * (S + 1) + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [3:0] src;
  logic       a_in;
  logic [1:0] sel;
  logic [3:0] y_q;
  logic       scan_done;
  logic       changed;
  logic       busy;

  always #5 clk = ~clk;

  assign a_in = src[sel];

  chan_scan_capture #(
    .SETTLE_CYCLES (S),
    .NUM_CH        (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .a_in      (a_in),
    .sel       (sel),
    .y_q       (y_q),
    .scan_done (scan_done),
    .changed   (changed),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: image and previous raw scan as plain vectors.
  logic [3:0] m_y, m_prev, m_raw;

  typedef struct {
    logic [3:0] src;
    logic [3:0] y;
    logic       chg;
  } vec_t;
  vec_t tbl[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    m_y = '0; m_prev = '0; m_raw = '0;
  endtask

  task automatic model_commit(output logic exp_chg);
    logic [3:0] ny;
    for (int i = 0; i < 4; i++) begin
`ifdef SCAN_DEBOUNCE_EN
      ny[i] = (m_raw[i] == m_prev[i]) ? m_raw[i] : m_y[i];
`else
      ny[i] = m_raw[i];
`endif
    end
    exp_chg = (ny != m_y);
    m_y     = ny;
    m_prev  = m_raw;
  endtask

  // Runs one scan starting from IDLE or from the previous COMMIT cycle.
  task automatic run_scan(input bit keep_en, input int drop_c, input bit rnd,
                          output logic [3:0] y_seen, output logic chg_seen);
    logic exp_chg;
    enable = 1'b1;
    for (int c = 1; c <= SCAN_LEN; c++) begin
      tick();
      if (c == 1 && !keep_en) enable = 1'b0;
      if (c == drop_c) enable = 1'b0;
      check("busy", busy, 1);
      check("scan_done", scan_done, (c == SCAN_LEN));
      if (c < SCAN_LEN) begin
        check("sel", sel, (c - 1) / (S + 1));
        check("changed_quiet", changed, 0);
      end else begin
        model_commit(exp_chg);
        check("y_model", y_q, m_y);
        check("changed_model", changed, exp_chg);
        y_seen   = y_q;
        chg_seen = changed;
      end
      if (rnd) src = 4'($urandom);
      if ((c % (S + 1)) == 0 && c < SCAN_LEN) m_raw[c / (S + 1) - 1] = src[c / (S + 1) - 1];
    end
  endtask

  initial begin
    logic [3:0] ys, y1, y3;
    logic       cs, c1;
    int         bad;

`ifdef SCAN_DEBOUNCE_EN
    tbl[0] = '{4'b0101, 4'b0000, 1'b0};
    tbl[1] = '{4'b0101, 4'b0101, 1'b1};
    tbl[2] = '{4'b1010, 4'b0101, 1'b0};
    tbl[3] = '{4'b0000, 4'b0000, 1'b1};
    tbl[4] = '{4'b1111, 4'b0000, 1'b0};
`else
    tbl[0] = '{4'b0101, 4'b0101, 1'b1};
    tbl[1] = '{4'b0101, 4'b0101, 1'b0};
    tbl[2] = '{4'b1010, 4'b1010, 1'b1};
    tbl[3] = '{4'b0000, 4'b0000, 1'b1};
    tbl[4] = '{4'b1111, 4'b1111, 1'b1};
`endif

    rst_n = 1'b0; enable = 1'b0; src = '0;
    model_reset();
    tick(); tick();
    check("rst_y", y_q, 0);
    check("rst_sel", sel, 0);
    check("rst_busy", busy, 0);
    check("rst_done", scan_done, 0);
    check("rst_changed", changed, 0);
    rst_n = 1'b1;
    tick();
    check("idle_busy", busy, 0);

    // Single-pulse scans from the table.
    for (int i = 0; i < 5; i++) begin
      src = tbl[i].src;
      run_scan(1'b0, 0, 1'b0, ys, cs);
      check("tbl_y", ys, tbl[i].y);
      check("tbl_changed", cs, tbl[i].chg);
      tick();
      check("tbl_idle_busy", busy, 0);
      check("tbl_idle_done", scan_done, 0);
      check("tbl_sel_hold", sel, 3);
    end

    // Back-to-back scans with enable held high.
    src = 4'b0101;
    run_scan(1'b1, 0, 1'b0, ys, cs);
    run_scan(1'b1, 0, 1'b0, ys, cs);
    check("cont_y", ys, 4'b0101);
    check("cont_nochange", cs, 0);
    src = 4'b1010;
    run_scan(1'b1, 0, 1'b0, ys, cs);
    run_scan(1'b1, 0, 1'b0, ys, cs);
    check("cont_y2", ys, 4'b1010);
    enable = 1'b0;
    tick();
    check("cont_idle", busy, 0);

    // Enable dropped while channel 1 is selected.
    src = 4'b0110;
    run_scan(1'b1, 5, 1'b0, ys, cs);
    bad = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (scan_done || busy) bad++;
    end
    check("drop_then_idle", bad, 0);

    // Reset while channel 2 is selected.
    src = 4'b1111;
    enable = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) enable = 1'b0;
    end
    check("pre_rst_sel", sel, 2);
    rst_n = 1'b0;
    tick();
    check("midrst_y", y_q, 0);
    check("midrst_sel", sel, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", scan_done, 0);
    rst_n = 1'b1;
    model_reset();
    bad = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (scan_done || busy) bad++;
    end
    check("midrst_quiet", bad, 0);

    // One-scan glitch on bit 3, scanning continuously from reset.
    src = 4'b0101;
    run_scan(1'b1, 0, 1'b0, y1, c1);
    run_scan(1'b1, 0, 1'b0, ys, cs);
`ifdef SCAN_DEBOUNCE_EN
    check("db_first_y", y1, 4'b0000);
    check("db_first_chg", c1, 0);
    check("db_second_y", ys, 4'b0101);
    check("db_second_chg", cs, 1);
`else
    check("nd_first_y", y1, 4'b0101);
    check("nd_first_chg", c1, 1);
    check("nd_second_chg", cs, 0);
`endif
    src = 4'b1101;
    run_scan(1'b1, 0, 1'b0, y3, cs);
    src = 4'b0101;
    run_scan(1'b1, 0, 1'b0, ys, cs);
`ifdef SCAN_DEBOUNCE_EN
    check("glitch_bit3", y3[3], 0);
`else
    check("glitch_bit3", y3[3], 1);
`endif
    check("glitch_after", ys[3], 0);
    enable = 1'b0;
    tick();

    // Randomized source lines changing every cycle.
    for (int r = 0; r < 20; r++) begin
      run_scan(1'b1, 0, 1'b1, ys, cs);
    end
    enable = 1'b0;
    tick();
    check("rand_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
